ctrl_pipe_hazard: RTL and testbench
===================================

// Module: ctrl_pipe_hazard
// PURPOSE
//  Consumer of the ID-stage control bundle produced by controlUnit. Carries the bundle
//  (with rd) through the ID/EX, EX/MEM and MEM/WB registers of the RV32I pipeline.
//  Detects load-use hazards, flushes on taken branch/jump and freezes on external
//  memory stall. Drives PC/IF-ID write enables and EX operand forwarding selects.
// PARAMETERS
//  REG_AW    5   register address width
//  CNT_W     16  width of saturating stall/flush event counters
// PORTS
//  clk                 in   1   pipeline clock, rising edge
//  rst_n               in   1   async active-low reset
//  ID_cntl_MemWrite    in   1   decoded store enable
//  ID_cntl_MemRead     in   1   decoded load enable
//  ID_cntl_RegWrite    in   1   decoded register write enable
//  ID_cntl_Branch      in   1   decoded conditional branch
//  ID_sel_MemToReg     in   3   writeback source select
//  ID_sel_ALUSrc       in   2   ALU operand source select
//  ID_sel_jump         in   2   jump type (00 none)
//  ID_ALUOp            in   4   ALU operation
//  ID_rs1, ID_rs2, ID_rd in REG_AW  ID source/dest register numbers
//  EX_branch_taken     in   1   branch condition true, resolved in EX
//  ext_stall           in   1   data/instr memory not ready: freeze pipeline
//  EX_*, MEM_*, WB_*   out  -   registered bundles (same fields/widths as ID_*, plus rd)
//  pc_write            out  1   PC register enable
//  ifid_write          out  1   IF/ID register enable
//  ifid_flush          out  1   IF/ID clear (inject NOP)
//  fwd_a, fwd_b        out  2   EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  stall_cnt, flush_cnt out CNT_W  saturating event counters
// BEHAVIOUR
//  Reset (async, rst_n=0): all EX/MEM/WB bundle fields and rd = 0 (NOP bundle);
//   counters = 0. Combinational outputs then: pc_write=1, ifid_write=1, ifid_flush=0,
//   fwd_a=fwd_b=00. Reset mid-operation discards all in-flight bundles immediately.
//  Per-cycle priority (first match wins):
//   1 ext_stall=1: EX/MEM/WB hold; pc_write=0, ifid_write=0, ifid_flush=0; no counts.
//   2 flush: EX_branch_taken=1 (with EX_cntl_Branch=1) or EX_sel_jump!=00.
//     EX <- NOP; MEM<-EX, WB<-MEM; ifid_flush=1; pc_write=1; flush_cnt++.
//   3 load-use: EX_cntl_MemRead & EX_rd!=0 & (EX_rd==ID_rs1 | EX_rd==ID_rs2).
//     EX <- NOP; MEM<-EX, WB<-MEM; pc_write=0, ifid_write=0; stall_cnt++.
//     Lasts exactly one cycle (bubble clears EX_cntl_MemRead).
//   4 normal: EX<-ID bundle, MEM<-EX, WB<-MEM; enables=1, flush=0.
//  Forwarding (combinational, from registered state, independent of stall):
//   fwd_a=01 if MEM_cntl_RegWrite & MEM_rd!=0 & MEM_rd==EX_rs1; else 10 if
//   WB_cntl_RegWrite & WB_rd!=0 & WB_rd==EX_rs1; else 00. MEM wins over WB.
//   fwd_b same with EX_rs2. EX_rs1/EX_rs2 registered alongside bundle (NOP -> 0).
//  x0 never hazards or forwards. Counters saturate at 2^CNT_W-1, never wrap.
//  Latency: ID bundle visible on EX_* 1 cycle later, MEM_* 2, WB_* 3 (absent stalls).
// STRUCTURE
//  Shared header ctrl_defs.vh: bundle field widths, bundle total width, NOP bundle
//  constant, jump encodings, fwd select codes (FWD_REG/FWD_MEM/FWD_WB).
//  Sub-module ctrl_stage_reg: one bundle register with hold and bubble inputs,
//  async reset to NOP; instantiated for EX, MEM, WB. Hazard/forward logic in top.
// TESTING
//  T1 reset: rst_n=0 with random ID inputs -> all EX/MEM/WB=0, pc_write=1, fwd=00,
//     counters=0; deassert -> ID bundle appears on EX next edge.
//  T2 load-use: EX load rd=5 (MemRead=1,RegWrite=1), ID rs1=5 -> pc_write=0,
//     ifid_write=0 one cycle, EX=NOP next edge, stall_cnt=1; rd=0 variant -> no stall.
//  T3 branch flush: EX Branch=1, EX_branch_taken=1 -> ifid_flush=1, EX<-NOP,
//     flush_cnt=1; EX_branch_taken=0 -> no flush. Jump 01/10 -> flush unconditionally.
//  T4 forwarding: MEM rd=3 RegWrite, WB rd=3 RegWrite, EX rs1=3 -> fwd_a=01;
//     MEM RegWrite=0 -> fwd_a=10; EX rs2=0 with WB rd=0 -> fwd_b=00.
//  T5 ext_stall: hold 3 cycles during load-use + taken branch -> all stages frozen,
//     counters unchanged; release -> flush applied first (priority), then normal flow.
//  T6 saturation: CNT_W=2, 5 load-use events -> stall_cnt=3.

Source files
------------

// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared types for the control-bundle pipeline: bundle layout, jump and forward encodings.
// The NOP bundle is all zeros, which is also the register reset value.
package ctrl_pipe_hazard_pkg;

   typedef struct packed {
      logic       mem_write;
      logic       mem_read;
      logic       reg_write;
      logic       branch;
      logic [2:0] mem_to_reg;
      logic [1:0] alu_src;
      logic [1:0] jump;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   localparam logic [1:0] JUMP_NONE = 2'b00;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipe_hazard_stage_reg.sv
// One pipeline bundle register: hold freezes it, bubble loads the all-zero NOP bundle.
module ctrl_pipe_hazard_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hold,
   input  logic         bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (!hold) begin
         q <= bubble ? '0 : d;
      end
   end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Carries the ID control bundle through EX/MEM/WB, resolving load-use stalls,
// branch/jump flushes, external freezes and EX operand forwarding.
module ctrl_pipe_hazard
   import ctrl_pipe_hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ID_cntl_MemWrite,
   input  logic              ID_cntl_MemRead,
   input  logic              ID_cntl_RegWrite,
   input  logic              ID_cntl_Branch,
   input  logic [2:0]        ID_sel_MemToReg,
   input  logic [1:0]        ID_sel_ALUSrc,
   input  logic [1:0]        ID_sel_jump,
   input  logic [3:0]        ID_ALUOp,
   input  logic [REG_AW-1:0] ID_rs1,
   input  logic [REG_AW-1:0] ID_rs2,
   input  logic [REG_AW-1:0] ID_rd,
   input  logic              EX_branch_taken,
   input  logic              ext_stall,
   output logic              EX_cntl_MemWrite,
   output logic              EX_cntl_MemRead,
   output logic              EX_cntl_RegWrite,
   output logic              EX_cntl_Branch,
   output logic [2:0]        EX_sel_MemToReg,
   output logic [1:0]        EX_sel_ALUSrc,
   output logic [1:0]        EX_sel_jump,
   output logic [3:0]        EX_ALUOp,
   output logic [REG_AW-1:0] EX_rs1,
   output logic [REG_AW-1:0] EX_rs2,
   output logic [REG_AW-1:0] EX_rd,
   output logic              MEM_cntl_MemWrite,
   output logic              MEM_cntl_MemRead,
   output logic              MEM_cntl_RegWrite,
   output logic              MEM_cntl_Branch,
   output logic [2:0]        MEM_sel_MemToReg,
   output logic [1:0]        MEM_sel_ALUSrc,
   output logic [1:0]        MEM_sel_jump,
   output logic [3:0]        MEM_ALUOp,
   output logic [REG_AW-1:0] MEM_rs1,
   output logic [REG_AW-1:0] MEM_rs2,
   output logic [REG_AW-1:0] MEM_rd,
   output logic              WB_cntl_MemWrite,
   output logic              WB_cntl_MemRead,
   output logic              WB_cntl_RegWrite,
   output logic              WB_cntl_Branch,
   output logic [2:0]        WB_sel_MemToReg,
   output logic [1:0]        WB_sel_ALUSrc,
   output logic [1:0]        WB_sel_jump,
   output logic [3:0]        WB_ALUOp,
   output logic [REG_AW-1:0] WB_rs1,
   output logic [REG_AW-1:0] WB_rs2,
   output logic [REG_AW-1:0] WB_rd,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int SW = CTRL_W + 3 * REG_AW;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ctrl_t         id_c;
   logic [SW-1:0] id_w, ex_w, mem_w, wb_w;
   logic          flush, load_use, ex_bubble;

   assign id_c = '{mem_write:  ID_cntl_MemWrite, mem_read: ID_cntl_MemRead,
                   reg_write:  ID_cntl_RegWrite, branch:   ID_cntl_Branch,
                   mem_to_reg: ID_sel_MemToReg,  alu_src:  ID_sel_ALUSrc,
                   jump:       ID_sel_jump,      alu_op:   ID_ALUOp};
   assign id_w = {id_c, ID_rs1, ID_rs2, ID_rd};

   ctrl_pipe_hazard_stage_reg #(.W(SW)) u_ex (
      .clk(clk), .rst_n(rst_n), .hold(ext_stall), .bubble(ex_bubble), .d(id_w), .q(ex_w)
   );
   ctrl_pipe_hazard_stage_reg #(.W(SW)) u_mem (
      .clk(clk), .rst_n(rst_n), .hold(ext_stall), .bubble(1'b0), .d(ex_w), .q(mem_w)
   );
   ctrl_pipe_hazard_stage_reg #(.W(SW)) u_wb (
      .clk(clk), .rst_n(rst_n), .hold(ext_stall), .bubble(1'b0), .d(mem_w), .q(wb_w)
   );

   // Stage words share the field order of the output port lists.
   assign {EX_cntl_MemWrite, EX_cntl_MemRead, EX_cntl_RegWrite, EX_cntl_Branch,
           EX_sel_MemToReg, EX_sel_ALUSrc, EX_sel_jump, EX_ALUOp,
           EX_rs1, EX_rs2, EX_rd} = ex_w;
   assign {MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite, MEM_cntl_Branch,
           MEM_sel_MemToReg, MEM_sel_ALUSrc, MEM_sel_jump, MEM_ALUOp,
           MEM_rs1, MEM_rs2, MEM_rd} = mem_w;
   assign {WB_cntl_MemWrite, WB_cntl_MemRead, WB_cntl_RegWrite, WB_cntl_Branch,
           WB_sel_MemToReg, WB_sel_ALUSrc, WB_sel_jump, WB_ALUOp,
           WB_rs1, WB_rs2, WB_rd} = wb_w;

   assign flush    = (EX_branch_taken & EX_cntl_Branch) | (EX_sel_jump != JUMP_NONE);
   assign load_use = EX_cntl_MemRead & (EX_rd != '0) & ((EX_rd == ID_rs1) | (EX_rd == ID_rs2));

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      ex_bubble  = 1'b0;
      if (ext_stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (flush) begin
         ifid_flush = 1'b1;
         ex_bubble  = 1'b1;
      end else if (load_use) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ex_bubble  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!ext_stall) begin
         if (flush) begin
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
         end else if (load_use) begin
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   // Younger producer (EX/MEM) wins; x0 is never a forwarding target.
   function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs,
                                         input logic mem_rw, input logic [REG_AW-1:0] mem_rd,
                                         input logic wb_rw, input logic [REG_AW-1:0] wb_rd);
      if (mem_rw && (mem_rd != '0) && (mem_rd == rs)) return FWD_MEM;
      if (wb_rw && (wb_rd != '0) && (wb_rd == rs)) return FWD_WB;
      return FWD_REG;
   endfunction

   assign fwd_a = fwd_pick(EX_rs1, MEM_cntl_RegWrite, MEM_rd, WB_cntl_RegWrite, WB_rd);
   assign fwd_b = fwd_pick(EX_rs2, MEM_cntl_RegWrite, MEM_rd, WB_cntl_RegWrite, WB_rd);

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scenario bench for ctrl_pipe_hazard: hazards, flushes, forwarding, freeze, saturation
// and a streamed bundle sequence checked against an expected queue at WB.
module tb_ctrl_pipe_hazard;

   logic clk, rst_n;
   logic [29:0] id_vec;
   logic EX_branch_taken, ext_stall;

   logic ID_cntl_MemWrite, ID_cntl_MemRead, ID_cntl_RegWrite, ID_cntl_Branch;
   logic [2:0] ID_sel_MemToReg;
   logic [1:0] ID_sel_ALUSrc, ID_sel_jump;
   logic [3:0] ID_ALUOp;
   logic [4:0] ID_rs1, ID_rs2, ID_rd;

   logic EX_cntl_MemWrite, EX_cntl_MemRead, EX_cntl_RegWrite, EX_cntl_Branch;
   logic [2:0] EX_sel_MemToReg;
   logic [1:0] EX_sel_ALUSrc, EX_sel_jump;
   logic [3:0] EX_ALUOp;
   logic [4:0] EX_rs1, EX_rs2, EX_rd;
   logic MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite, MEM_cntl_Branch;
   logic [2:0] MEM_sel_MemToReg;
   logic [1:0] MEM_sel_ALUSrc, MEM_sel_jump;
   logic [3:0] MEM_ALUOp;
   logic [4:0] MEM_rs1, MEM_rs2, MEM_rd;
   logic WB_cntl_MemWrite, WB_cntl_MemRead, WB_cntl_RegWrite, WB_cntl_Branch;
   logic [2:0] WB_sel_MemToReg;
   logic [1:0] WB_sel_ALUSrc, WB_sel_jump;
   logic [3:0] WB_ALUOp;
   logic [4:0] WB_rs1, WB_rs2, WB_rd;

   logic pc_write, ifid_write, ifid_flush;
   logic [1:0] fwd_a, fwd_b;
   logic [1:0] stall_cnt, flush_cnt;

   logic [29:0] ex_vec, mem_vec, wb_vec;
   logic [29:0] exp_q[$];
   int total, bad;

   assign {ID_cntl_MemWrite, ID_cntl_MemRead, ID_cntl_RegWrite, ID_cntl_Branch,
           ID_sel_MemToReg, ID_sel_ALUSrc, ID_sel_jump, ID_ALUOp,
           ID_rs1, ID_rs2, ID_rd} = id_vec;
   assign ex_vec = {EX_cntl_MemWrite, EX_cntl_MemRead, EX_cntl_RegWrite, EX_cntl_Branch,
                    EX_sel_MemToReg, EX_sel_ALUSrc, EX_sel_jump, EX_ALUOp,
                    EX_rs1, EX_rs2, EX_rd};
   assign mem_vec = {MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite, MEM_cntl_Branch,
                     MEM_sel_MemToReg, MEM_sel_ALUSrc, MEM_sel_jump, MEM_ALUOp,
                     MEM_rs1, MEM_rs2, MEM_rd};
   assign wb_vec = {WB_cntl_MemWrite, WB_cntl_MemRead, WB_cntl_RegWrite, WB_cntl_Branch,
                    WB_sel_MemToReg, WB_sel_ALUSrc, WB_sel_jump, WB_ALUOp,
                    WB_rs1, WB_rs2, WB_rd};

   ctrl_pipe_hazard #(.REG_AW(5), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_cntl_MemWrite(ID_cntl_MemWrite), .ID_cntl_MemRead(ID_cntl_MemRead),
      .ID_cntl_RegWrite(ID_cntl_RegWrite), .ID_cntl_Branch(ID_cntl_Branch),
      .ID_sel_MemToReg(ID_sel_MemToReg), .ID_sel_ALUSrc(ID_sel_ALUSrc),
      .ID_sel_jump(ID_sel_jump), .ID_ALUOp(ID_ALUOp),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
      .EX_branch_taken(EX_branch_taken), .ext_stall(ext_stall),
      .EX_cntl_MemWrite(EX_cntl_MemWrite), .EX_cntl_MemRead(EX_cntl_MemRead),
      .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_Branch(EX_cntl_Branch),
      .EX_sel_MemToReg(EX_sel_MemToReg), .EX_sel_ALUSrc(EX_sel_ALUSrc),
      .EX_sel_jump(EX_sel_jump), .EX_ALUOp(EX_ALUOp),
      .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
      .MEM_cntl_MemWrite(MEM_cntl_MemWrite), .MEM_cntl_MemRead(MEM_cntl_MemRead),
      .MEM_cntl_RegWrite(MEM_cntl_RegWrite), .MEM_cntl_Branch(MEM_cntl_Branch),
      .MEM_sel_MemToReg(MEM_sel_MemToReg), .MEM_sel_ALUSrc(MEM_sel_ALUSrc),
      .MEM_sel_jump(MEM_sel_jump), .MEM_ALUOp(MEM_ALUOp),
      .MEM_rs1(MEM_rs1), .MEM_rs2(MEM_rs2), .MEM_rd(MEM_rd),
      .WB_cntl_MemWrite(WB_cntl_MemWrite), .WB_cntl_MemRead(WB_cntl_MemRead),
      .WB_cntl_RegWrite(WB_cntl_RegWrite), .WB_cntl_Branch(WB_cntl_Branch),
      .WB_sel_MemToReg(WB_sel_MemToReg), .WB_sel_ALUSrc(WB_sel_ALUSrc),
      .WB_sel_jump(WB_sel_jump), .WB_ALUOp(WB_ALUOp),
      .WB_rs1(WB_rs1), .WB_rs2(WB_rs2), .WB_rd(WB_rd),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle builder: chosen hazard fields, random don't-care fields.
   function automatic logic [29:0] mk(input logic mr, input logic rw, input logic br,
                                      input logic [1:0] jmp, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd);
      logic [29:0] v;
      v = {1'($urandom_range(0, 1)), mr, rw, br, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), jmp, 4'($urandom_range(0, 15)), rs1, rs2, rd};
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [29:0] v);
      @(negedge clk);
      id_vec = v;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      id_vec = '0;
      ext_stall = 1'b0;
      EX_branch_taken = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [29:0] v;
      rst_n = 1'b0;
      ext_stall = 1'b0;
      EX_branch_taken = 1'b0;
      id_vec = 30'($urandom);
      repeat (2) @(negedge clk);
      id_vec = 30'($urandom);
      #1;
      total++; if (ex_vec !== '0) begin bad++; $display("FAIL rst_ex got=%h exp=0", ex_vec); end
      total++; if (mem_vec !== '0) begin bad++; $display("FAIL rst_mem got=%h exp=0", mem_vec); end
      total++; if (wb_vec !== '0) begin bad++; $display("FAIL rst_wb got=%h exp=0", wb_vec); end
      total++; if ({pc_write, ifid_write, ifid_flush} !== 3'b110) begin
         bad++; $display("FAIL rst_enables got=%b exp=110", {pc_write, ifid_write, ifid_flush});
      end
      total++; if ({fwd_a, fwd_b} !== 4'b0000) begin bad++; $display("FAIL rst_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
      total++; if ({stall_cnt, flush_cnt} !== 4'b0000) begin
         bad++; $display("FAIL rst_cnt got=%b exp=0000", {stall_cnt, flush_cnt});
      end
      v = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd3);
      @(negedge clk);
      id_vec = v;
      rst_n = 1'b1;
      tick();
      total++; if (ex_vec !== v) begin bad++; $display("FAIL rst_first_ex got=%h exp=%h", ex_vec, v); end
   endtask

   task automatic test_load_use;
      logic [29:0] ld, use_i;
      do_reset();
      ld = mk(1'b1, 1'b1, 1'b0, 2'b00, 5'd7, 5'd8, 5'd5);
      use_i = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 5'd9, 5'd6);
      drive(ld);
      tick();
      drive(use_i);
      #1;
      total++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin
         bad++; $display("FAIL lu_enables got=%b exp=000", {pc_write, ifid_write, ifid_flush});
      end
      tick();
      total++; if (ex_vec !== '0) begin bad++; $display("FAIL lu_bubble got=%h exp=0", ex_vec); end
      total++; if (mem_vec !== ld) begin bad++; $display("FAIL lu_mem got=%h exp=%h", mem_vec, ld); end
      total++; if (stall_cnt !== 2'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
      total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_one_cycle got=%b exp=1", pc_write); end
      tick();
      total++; if (ex_vec !== use_i) begin bad++; $display("FAIL lu_resume got=%h exp=%h", ex_vec, use_i); end
      // rd = x0 load never stalls
      do_reset();
      ld = mk(1'b1, 1'b1, 1'b0, 2'b00, 5'd7, 5'd8, 5'd0);
      use_i = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd6);
      drive(ld);
      tick();
      drive(use_i);
      #1;
      total++; if ({pc_write, ifid_write} !== 2'b11) begin bad++; $display("FAIL lu_x0_en got=%b exp=11", {pc_write, ifid_write}); end
      tick();
      total++; if (ex_vec !== use_i) begin bad++; $display("FAIL lu_x0_ex got=%h exp=%h", ex_vec, use_i); end
      total++; if (stall_cnt !== 2'd0) begin bad++; $display("FAIL lu_x0_cnt got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_branch_flush;
      logic [29:0] br, nxt;
      do_reset();
      br = mk(1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 5'd2, 5'd0);
      nxt = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd3, 5'd4, 5'd7);
      drive(br);
      tick();
      drive(nxt);
      EX_branch_taken = 1'b1;
      #1;
      total++; if ({ifid_flush, pc_write} !== 2'b11) begin bad++; $display("FAIL br_flush got=%b exp=11", {ifid_flush, pc_write}); end
      tick();
      total++; if (ex_vec !== '0) begin bad++; $display("FAIL br_ex_nop got=%h exp=0", ex_vec); end
      total++; if (mem_vec !== br) begin bad++; $display("FAIL br_mem got=%h exp=%h", mem_vec, br); end
      total++; if (flush_cnt !== 2'd1) begin bad++; $display("FAIL br_cnt got=%0d exp=1", flush_cnt); end
      total++; if (ifid_flush !== 1'b0) begin bad++; $display("FAIL br_after_nop got=%b exp=0", ifid_flush); end
      do_reset();
      drive(br);
      tick();
      drive(nxt);
      #1;
      total++; if (ifid_flush !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b exp=0", ifid_flush); end
      tick();
      total++; if (ex_vec !== nxt) begin bad++; $display("FAIL br_nt_ex got=%h exp=%h", ex_vec, nxt); end
      total++; if (flush_cnt !== 2'd0) begin bad++; $display("FAIL br_nt_cnt got=%0d exp=0", flush_cnt); end
   endtask

   task automatic test_jump_flush;
      logic [29:0] jp, nxt;
      for (int j = 1; j <= 2; j++) begin
         do_reset();
         jp = mk(1'b0, 1'b1, 1'b0, 2'(j), 5'd1, 5'd0, 5'd1);
         nxt = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd3, 5'd4, 5'd7);
         drive(jp);
         tick();
         drive(nxt);
         #1;
         total++; if (ifid_flush !== 1'b1) begin bad++; $display("FAIL jmp%0d_flush got=%b exp=1", j, ifid_flush); end
         tick();
         total++; if (ex_vec !== '0) begin bad++; $display("FAIL jmp%0d_ex got=%h exp=0", j, ex_vec); end
         total++; if (flush_cnt !== 2'd1) begin bad++; $display("FAIL jmp%0d_cnt got=%0d exp=1", j, flush_cnt); end
      end
   endtask

   task automatic run3(input logic [29:0] a, input logic [29:0] b, input logic [29:0] c);
      do_reset();
      drive(a);
      tick();
      drive(b);
      tick();
      drive(c);
      tick();
   endtask

   task automatic test_forwarding;
      run3(mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd10, 5'd11, 5'd3),
           mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd12, 5'd13, 5'd3),
           mk(1'b0, 1'b0, 1'b0, 2'b00, 5'd3, 5'd0, 5'd9));
      total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_mem_wins got=%b exp=01", fwd_a); end
      total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_b_x0 got=%b exp=00", fwd_b); end
      run3(mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd10, 5'd11, 5'd3),
           mk(1'b0, 1'b0, 1'b0, 2'b00, 5'd12, 5'd13, 5'd3),
           mk(1'b0, 1'b0, 1'b0, 2'b00, 5'd3, 5'd0, 5'd9));
      total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_wb got=%b exp=10", fwd_a); end
      run3(mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd10, 5'd11, 5'd0),
           mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd12, 5'd13, 5'd0),
           mk(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd9));
      total++; if ({fwd_a, fwd_b} !== 4'b0000) begin bad++; $display("FAIL fwd_rd_x0 got=%b exp=0000", {fwd_a, fwd_b}); end
      run3(mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd10, 5'd11, 5'd4),
           mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd12, 5'd13, 5'd8),
           mk(1'b0, 1'b0, 1'b0, 2'b00, 5'd4, 5'd8, 5'd9));
      total++; if ({fwd_a, fwd_b} !== 4'b1001) begin bad++; $display("FAIL fwd_split got=%b exp=1001", {fwd_a, fwd_b}); end
   endtask

   task automatic test_ext_stall;
      logic [29:0] p1, p2, x, use_i;
      p1 = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd4);
      p2 = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd6);
      x = mk(1'b1, 1'b1, 1'b1, 2'b00, 5'd7, 5'd8, 5'd5);
      use_i = mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 5'd5, 5'd9);
      run3(p1, p2, x);
      drive(use_i);
      EX_branch_taken = 1'b1;
      ext_stall = 1'b1;
      #1;
      total++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin
         bad++; $display("FAIL xs_enables got=%b exp=000", {pc_write, ifid_write, ifid_flush});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({ex_vec, mem_vec, wb_vec} !== {x, p2, p1}) begin
            bad++; $display("FAIL xs_hold%0d got=%h/%h/%h exp=%h/%h/%h", i, ex_vec, mem_vec, wb_vec, x, p2, p1);
         end
         total++; if ({stall_cnt, flush_cnt} !== 4'b0000) begin
            bad++; $display("FAIL xs_cnt%0d got=%b exp=0000", i, {stall_cnt, flush_cnt});
         end
      end
      @(negedge clk);
      ext_stall = 1'b0;
      #1;
      total++; if ({ifid_flush, pc_write} !== 2'b11) begin bad++; $display("FAIL xs_release got=%b exp=11", {ifid_flush, pc_write}); end
      tick();
      total++; if ({ex_vec, mem_vec, wb_vec} !== {30'd0, x, p2}) begin
         bad++; $display("FAIL xs_flush got=%h/%h/%h exp=0/%h/%h", ex_vec, mem_vec, wb_vec, x, p2);
      end
      total++; if ({stall_cnt, flush_cnt} !== 4'b0001) begin
         bad++; $display("FAIL xs_cnt_after got=%b exp=0001", {stall_cnt, flush_cnt});
      end
      @(negedge clk);
      EX_branch_taken = 1'b0;
      tick();
      total++; if (ex_vec !== use_i) begin bad++; $display("FAIL xs_normal got=%h exp=%h", ex_vec, use_i); end
   endtask

   task automatic test_saturation;
      logic [29:0] ld, use_i;
      int exp_cnt;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         ld = mk(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'(k + 10));
         use_i = (k % 2 == 0) ? mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'(k + 10), 5'd2)
                              : mk(1'b0, 1'b1, 1'b0, 2'b00, 5'(k + 10), 5'd1, 5'd2);
         drive(ld);
         tick();
         drive(use_i);
         tick();
         exp_cnt = (k > 3) ? 3 : k;
         total++; if (stall_cnt !== 2'(exp_cnt)) begin
            bad++; $display("FAIL sat_ev%0d got=%0d exp=%0d", k, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [29:0] nxt, exp_v;
      int n;
      n = 20;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < n + 3; i++) begin
         @(negedge clk);
         if (i >= 3) begin
            exp_v = exp_q.pop_front();
            total++; if (wb_vec !== exp_v) begin bad++; $display("FAIL b2b_wb%0d got=%h exp=%h", i, wb_vec, exp_v); end
         end
         nxt = (i < n) ? mk(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00,
                            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)))
                       : 30'd0;
         id_vec = nxt;
         exp_q.push_back(nxt);
      end
      exp_q.delete();
      // async reset between edges drops everything in flight
      for (int i = 0; i < 3; i++) drive(mk(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd3));
      tick();
      #2 rst_n = 1'b0;
      #1;
      total++; if ({ex_vec, mem_vec, wb_vec} !== 90'd0) begin
         bad++; $display("FAIL mid_reset got=%h/%h/%h exp=0", ex_vec, mem_vec, wb_vec);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_load_use();
      test_branch_flush();
      test_jump_flush();
      test_forwarding();
      test_ext_stall();
      test_saturation();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
